iram_arbiter: RTL and testbench

- Shares the single-port instruction RAM between three requesters: core instruction fetch (IF), core load/store unit (LSU), and the external program loader (UART/JTAG ISP).
- In run mode it arbitrates IF against LSU, with starvation protection for IF.
- In load mode it halts the core, drains in-flight accesses and gives the loader exclusive access. On exit it pulses a core reset request.
- Sits between core/loader and the iram dual-port wrapper's port A.

---
 rtl/iram_arbiter_pkg.sv | 27 ++
 rtl/iram_arb_starve.sv | 46 ++++
 rtl/iram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_iram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iram_arbiter_pkg.sv
// ------------------------------------------------------------------
// iram_arbiter_pkg : shared types and constants for the IRAM arbiter
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package iram_arbiter_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2,
    OWN_LD   = 2'd3
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/iram_arb_starve.sv
// ------------------------------------------------------------------
// iram_arb_starve : saturating count of consecutive denied IF cycles
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module iram_arb_starve
  import iram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic max_o
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  // Clear dominates so a grant in the same cycle never leaves a stale count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max_o = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/iram_arbiter.sv
// ------------------------------------------------------------------
// iram_arbiter : IRAM port-A arbiter for IF / LSU / program loader
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module iram_arbiter
  import iram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic              lsu_req_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              lsu_we_i,
  input  logic              ld_we_i,
  input  logic [31:0]       lsu_wdata_i,
  input  logic [31:0]       ld_wdata_i,
  input  logic [3:0]        lsu_wem_i,
  input  logic [3:0]        ld_wem_i,
  output logic              if_gnt_o,
  output logic              lsu_gnt_o,
  output logic              ld_gnt_o,
  output logic              if_rvalid_o,
  output logic              lsu_rvalid_o,
  output logic              ld_rvalid_o,
  output logic [31:0]       rdata_o,
  input  logic              ld_mode_i,
  output logic              core_halt_o,
  output logic              core_rst_req_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wem_o,
  input  logic [31:0]       mem_rdata_i
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_e     owner_q;
  owner_e     owner_d;
  logic       core_halt_q;
  logic       core_halt_d;
  logic       core_rst_req_q;
  logic       core_rst_req_d;

  logic if_gnt;
  logic lsu_gnt;
  logic ld_gnt;
  logic starve_max;
  logic starve_inc;
  logic starve_clr;

  iram_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .max_o (starve_max)
  );

  // Core requesters only compete in RUN; the loader owns the port in LOAD
  always_comb begin
    if_gnt  = 1'b0;
    lsu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (if_req_i && (starve_max || !lsu_req_i)) begin
          if_gnt = 1'b1;
        end else begin
          lsu_gnt = lsu_req_i;
        end
      end
      ST_LOAD: begin
        ld_gnt = ld_req_i;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    mem_en_o    = if_gnt | lsu_gnt | ld_gnt;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wem_o   = '0;
    if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end else if (lsu_gnt) begin
      mem_we_o    = lsu_we_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
      mem_wem_o   = lsu_wem_i;
    end else if (ld_gnt) begin
      mem_we_o    = ld_we_i;
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
      mem_wem_o   = ld_wem_i;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (lsu_gnt) begin
      owner_d = OWN_LSU;
    end else if (ld_gnt) begin
      owner_d = OWN_LD;
    end
  end

  assign starve_inc = if_req_i && !if_gnt;
  assign starve_clr = if_gnt || (state_q == ST_RELEASE);

  // DRAIN is committed: once entered, the loader always gets its window
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (ld_mode_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (owner_q == OWN_NONE) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!ld_mode_i && !ld_gnt && (owner_q == OWN_NONE)) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    core_halt_d    = (state_d != ST_RUN);
    core_rst_req_d = (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      owner_q        <= OWN_NONE;
      core_halt_q    <= 1'b0;
      core_rst_req_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      core_halt_q    <= core_halt_d;
      core_rst_req_q <= core_rst_req_d;
    end
  end

  assign if_gnt_o       = if_gnt;
  assign lsu_gnt_o      = lsu_gnt;
  assign ld_gnt_o       = ld_gnt;
  assign if_rvalid_o    = (owner_q == OWN_IF);
  assign lsu_rvalid_o   = (owner_q == OWN_LSU);
  assign ld_rvalid_o    = (owner_q == OWN_LD);
  assign rdata_o        = mem_rdata_i;
  assign core_halt_o    = core_halt_q;
  assign core_rst_req_o = core_rst_req_q;

endmodule

`default_nettype wire

// File: tb/tb_iram_arbiter.sv
// ------------------------------------------------------------------
// tb_iram_arbiter : self-checking bench for iram_arbiter with RAM model
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_iram_arbiter;

  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req_i, lsu_req_i, ld_req_i;
  logic [ADDR_W-1:0] if_addr_i, lsu_addr_i, ld_addr_i;
  logic              lsu_we_i, ld_we_i;
  logic [31:0]       lsu_wdata_i, ld_wdata_i;
  logic [3:0]        lsu_wem_i, ld_wem_i;
  logic              if_gnt_o, lsu_gnt_o, ld_gnt_o;
  logic              if_rvalid_o, lsu_rvalid_o, ld_rvalid_o;
  logic [31:0]       rdata_o;
  logic              ld_mode_i;
  logic              core_halt_o, core_rst_req_o;
  logic              mem_en_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wem_o;
  logic [31:0]       mem_rdata_i;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] ram     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:63];
  logic [31:0] ld_data [0:7];

  always #5 clk = ~clk;

  iram_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_i       (if_req_i),
    .lsu_req_i      (lsu_req_i),
    .ld_req_i       (ld_req_i),
    .if_addr_i      (if_addr_i),
    .lsu_addr_i     (lsu_addr_i),
    .ld_addr_i      (ld_addr_i),
    .lsu_we_i       (lsu_we_i),
    .ld_we_i        (ld_we_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .ld_wdata_i     (ld_wdata_i),
    .lsu_wem_i      (lsu_wem_i),
    .ld_wem_i       (ld_wem_i),
    .if_gnt_o       (if_gnt_o),
    .lsu_gnt_o      (lsu_gnt_o),
    .ld_gnt_o       (ld_gnt_o),
    .if_rvalid_o    (if_rvalid_o),
    .lsu_rvalid_o   (lsu_rvalid_o),
    .ld_rvalid_o    (ld_rvalid_o),
    .rdata_o        (rdata_o),
    .ld_mode_i      (ld_mode_i),
    .core_halt_o    (core_halt_o),
    .core_rst_req_o (core_rst_req_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_wem_o      (mem_wem_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Single-port RAM with one-cycle read latency behind port A
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_i <= ram[mem_addr_o];
      if (mem_we_o) ram[mem_addr_o] <= merge(ram[mem_addr_o], mem_wdata_o, mem_wem_o);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; lsu_req_i = 1'b0; ld_req_i = 1'b0;
    lsu_we_i = 1'b0; ld_we_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if ({if_gnt_o, lsu_gnt_o, ld_gnt_o, if_rvalid_o, lsu_rvalid_o, ld_rvalid_o, core_halt_o, core_rst_req_o, mem_en_o} !== 9'b0) begin
      nmis++; $display("FAIL reset_outputs: got %b want %b", {if_gnt_o, lsu_gnt_o, ld_gnt_o, if_rvalid_o, lsu_rvalid_o, ld_rvalid_o, core_halt_o, core_rst_req_o, mem_en_o}, 9'b0);
    end
    @(posedge clk); #1;
    nvec++;
    if ({if_rvalid_o, lsu_rvalid_o, ld_rvalid_o, core_halt_o, core_rst_req_o, mem_en_o} !== 6'b0) begin
      nmis++; $display("FAIL reset_after_edge: got %b want %b", {if_rvalid_o, lsu_rvalid_o, ld_rvalid_o, core_halt_o, core_rst_req_o, mem_en_o}, 6'b0);
    end
    #2 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_if_read();
    if_req_i = 1'b1; if_addr_i = 14'h010;
    #1;
    nvec++;
    if ({if_gnt_o, lsu_gnt_o, ld_gnt_o, mem_en_o, mem_we_o} !== 5'b10010 || mem_addr_o !== 14'h010) begin
      nmis++; $display("FAIL if_read_gnt: got gnt/en/we %b addr %h want 10010 addr 010", {if_gnt_o, lsu_gnt_o, ld_gnt_o, mem_en_o, mem_we_o}, mem_addr_o);
    end
    next_cycle();
    if_req_i = 1'b0;
    nvec++;
    if ({if_rvalid_o, lsu_rvalid_o, ld_rvalid_o} !== 3'b100 || rdata_o !== 32'hDEADBEEF) begin
      nmis++; $display("FAIL if_read_resp: got rvalid %b rdata %h want 100 deadbeef", {if_rvalid_o, lsu_rvalid_o, ld_rvalid_o}, rdata_o);
    end
  endtask

  task automatic test_starve();
    logic exp_if;
    logic prev_if;
    if_req_i = 1'b1; if_addr_i = 14'h041;
    lsu_req_i = 1'b1; lsu_addr_i = 14'h040; lsu_we_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp_if = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
      nvec++;
      if ({if_gnt_o, lsu_gnt_o} !== {exp_if, !exp_if}) begin
        nmis++; $display("FAIL starve_pattern[%0d]: got if/lsu %b want %b", i, {if_gnt_o, lsu_gnt_o}, {exp_if, !exp_if});
      end
      prev_if = exp_if;
      next_cycle();
      nvec++;
      if ({if_rvalid_o, lsu_rvalid_o} !== {prev_if, !prev_if}) begin
        nmis++; $display("FAIL starve_rvalid[%0d]: got if/lsu %b want %b", i, {if_rvalid_o, lsu_rvalid_o}, {prev_if, !prev_if});
      end
    end
    idle_inputs();
  endtask

  task automatic test_wem();
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 14'h020;
    lsu_wdata_i = 32'h12345678; lsu_wem_i = 4'b0011;
    #1;
    nvec++;
    if ({lsu_gnt_o, mem_we_o} !== 2'b11 || mem_wem_o !== 4'b0011 || mem_wdata_o !== 32'h12345678 || mem_addr_o !== 14'h020) begin
      nmis++; $display("FAIL wem_write: got gnt/we %b wem %b wdata %h addr %h", {lsu_gnt_o, mem_we_o}, mem_wem_o, mem_wdata_o, mem_addr_o);
    end
    next_cycle();
    idle_inputs();
    nvec++;
    if (lsu_rvalid_o !== 1'b1) begin
      nmis++; $display("FAIL wem_ack: got lsu_rvalid %b want 1", lsu_rvalid_o);
    end
    if_req_i = 1'b1; if_addr_i = 14'h020;
    next_cycle();
    if_req_i = 1'b0;
    nvec++;
    if (if_rvalid_o !== 1'b1 || rdata_o !== 32'hFFFF5678) begin
      nmis++; $display("FAIL wem_readback: got rvalid %b rdata %h want 1 ffff5678", if_rvalid_o, rdata_o);
    end
  endtask

  task automatic test_random();
    int denied;
    int exp_kind;
    logic exp_if, exp_lsu, exp_rd, if_done, lsu_done;
    logic [31:0] exp_data;
    logic [ADDR_W-1:0] exp_addr;
    denied = 0; if_done = 1'b1; lsu_done = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!if_req_i || if_done) begin
        if_req_i  = 1'($urandom_range(0, 1));
        if_addr_i = ADDR_W'(32'h40 + $urandom_range(0, 63));
      end
      if (!lsu_req_i || lsu_done) begin
        lsu_req_i   = 1'($urandom_range(0, 1));
        lsu_addr_i  = ADDR_W'(32'h40 + $urandom_range(0, 63));
        lsu_we_i    = 1'($urandom_range(0, 1));
        lsu_wdata_i = $urandom;
        lsu_wem_i   = 4'($urandom_range(0, 15));
      end
      #1;
      // Reference: LSU has priority unless IF has been refused STARVE_MAX times in a row
      exp_if  = if_req_i && (!lsu_req_i || denied >= STARVE_MAX);
      exp_lsu = lsu_req_i && !exp_if;
      exp_addr = exp_if ? if_addr_i : lsu_addr_i;
      nvec++;
      if ({if_gnt_o, lsu_gnt_o, ld_gnt_o} !== {exp_if, exp_lsu, 1'b0} || (mem_en_o && mem_addr_o !== exp_addr)) begin
        nmis++; $display("FAIL rand_gnt[%0d]: got %b addr %h want %b addr %h", i, {if_gnt_o, lsu_gnt_o, ld_gnt_o}, mem_addr_o, {exp_if, exp_lsu, 1'b0}, exp_addr);
      end
      if (exp_if) denied = 0;
      else if (if_req_i && denied < STARVE_MAX) denied++;
      exp_kind = exp_if ? 1 : (exp_lsu ? 2 : 0);
      exp_rd = exp_if || (exp_lsu && !lsu_we_i);
      exp_data = ref_mem[exp_addr[5:0]];
      if (exp_lsu && lsu_we_i) ref_mem[exp_addr[5:0]] = merge(ref_mem[exp_addr[5:0]], lsu_wdata_i, lsu_wem_i);
      if_done = exp_if; lsu_done = exp_lsu;
      next_cycle();
      nvec++;
      if ({if_rvalid_o, lsu_rvalid_o} !== {exp_kind == 1, exp_kind == 2} || (exp_rd && rdata_o !== exp_data)) begin
        nmis++; $display("FAIL rand_resp[%0d]: got rvalid %b rdata %h want %b %h", i, {if_rvalid_o, lsu_rvalid_o}, rdata_o, {exp_kind == 1, exp_kind == 2}, exp_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_drain_load();
    for (int i = 0; i < 8; i++) ld_data[i] = $urandom;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 14'h020; ld_mode_i = 1'b1;
    #1;
    nvec++;
    if ({lsu_gnt_o, core_halt_o} !== 2'b10) begin
      nmis++; $display("FAIL drain_entry_gnt: got lsu_gnt/halt %b want 10", {lsu_gnt_o, core_halt_o});
    end
    next_cycle();
    nvec++;
    if ({lsu_rvalid_o, core_halt_o} !== 2'b11 || rdata_o !== 32'hFFFF5678) begin
      nmis++; $display("FAIL drain_rvalid: got rvalid/halt %b rdata %h want 11 ffff5678", {lsu_rvalid_o, core_halt_o}, rdata_o);
    end
    if_req_i = 1'b1; if_addr_i = 14'h003;
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 14'h000; ld_wdata_i = ld_data[0]; ld_wem_i = 4'hF;
    #1;
    nvec++;
    if ({if_gnt_o, lsu_gnt_o, ld_gnt_o, mem_en_o} !== 4'b0) begin
      nmis++; $display("FAIL drain_nogrant1: got %b want 0000", {if_gnt_o, lsu_gnt_o, ld_gnt_o, mem_en_o});
    end
    next_cycle();
    #1;
    nvec++;
    if ({if_gnt_o, lsu_gnt_o, ld_gnt_o, core_halt_o, lsu_rvalid_o} !== 5'b00010) begin
      nmis++; $display("FAIL drain_nogrant2: got gnt/halt/rv %b want 00010", {if_gnt_o, lsu_gnt_o, ld_gnt_o, core_halt_o, lsu_rvalid_o});
    end
    next_cycle();
    #1;
    nvec++;
    if ({if_gnt_o, lsu_gnt_o, ld_gnt_o, core_halt_o, mem_we_o} !== 5'b00111 || mem_addr_o !== 14'h000) begin
      nmis++; $display("FAIL load_first_gnt: got gnt/halt/we %b addr %h want 00111 000", {if_gnt_o, lsu_gnt_o, ld_gnt_o, core_halt_o, mem_we_o}, mem_addr_o);
    end
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      nvec++;
      if (ld_rvalid_o !== 1'b1) begin
        nmis++; $display("FAIL load_ack[%0d]: got %b want 1", i - 1, ld_rvalid_o);
      end
      ld_addr_i = ADDR_W'(i); ld_wdata_i = ld_data[i];
      #1;
      nvec++;
      if (ld_gnt_o !== 1'b1 || mem_addr_o !== ADDR_W'(i)) begin
        nmis++; $display("FAIL load_gnt[%0d]: got gnt %b addr %h want 1 %h", i, ld_gnt_o, mem_addr_o, ADDR_W'(i));
      end
    end
    next_cycle();
    ld_req_i = 1'b0; ld_we_i = 1'b0; ld_mode_i = 1'b0;
    nvec++;
    if ({ld_rvalid_o, core_halt_o, core_rst_req_o} !== 3'b110) begin
      nmis++; $display("FAIL load_last_ack: got rvalid/halt/rst %b want 110", {ld_rvalid_o, core_halt_o, core_rst_req_o});
    end
    next_cycle();
    nvec++;
    if ({ld_rvalid_o, core_halt_o, core_rst_req_o} !== 3'b010) begin
      nmis++; $display("FAIL load_exit_wait: got rvalid/halt/rst %b want 010", {ld_rvalid_o, core_halt_o, core_rst_req_o});
    end
    next_cycle();
    nvec++;
    if ({core_halt_o, core_rst_req_o} !== 2'b11) begin
      nmis++; $display("FAIL release_pulse: got halt/rst %b want 11", {core_halt_o, core_rst_req_o});
    end
    if_req_i = 1'b1; if_addr_i = 14'h003;
    #1;
    nvec++;
    if (if_gnt_o !== 1'b0) begin
      nmis++; $display("FAIL release_nogrant: got if_gnt %b want 0", if_gnt_o);
    end
    next_cycle();
    nvec++;
    if ({core_halt_o, core_rst_req_o} !== 2'b00) begin
      nmis++; $display("FAIL run_after_release: got halt/rst %b want 00", {core_halt_o, core_rst_req_o});
    end
    #1;
    nvec++;
    if (if_gnt_o !== 1'b1) begin
      nmis++; $display("FAIL run_if_gnt: got %b want 1", if_gnt_o);
    end
    next_cycle();
    if_req_i = 1'b0;
    nvec++;
    if (if_rvalid_o !== 1'b1 || rdata_o !== ld_data[3]) begin
      nmis++; $display("FAIL loaded_word_read: got rvalid %b rdata %h want 1 %h", if_rvalid_o, rdata_o, ld_data[3]);
    end
  endtask

  task automatic test_reset_in_load();
    ld_mode_i = 1'b1;
    next_cycle();
    next_cycle();
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 14'h100; ld_wdata_i = 32'hCAFEF00D; ld_wem_i = 4'hF;
    #1;
    nvec++;
    if (ld_gnt_o !== 1'b1) begin
      nmis++; $display("FAIL rstload_gnt: got %b want 1", ld_gnt_o);
    end
    next_cycle();
    ld_req_i = 1'b0; ld_we_i = 1'b0;
    nvec++;
    if ({ld_rvalid_o, core_halt_o} !== 2'b11) begin
      nmis++; $display("FAIL rstload_pre: got rvalid/halt %b want 11", {ld_rvalid_o, core_halt_o});
    end
    #2 rst_n = 1'b0;
    ld_mode_i = 1'b0;
    #1;
    nvec++;
    if ({ld_rvalid_o, if_rvalid_o, lsu_rvalid_o, core_halt_o, core_rst_req_o} !== 5'b0) begin
      nmis++; $display("FAIL rstload_async: got rvalids/halt/rst %b want 00000", {ld_rvalid_o, if_rvalid_o, lsu_rvalid_o, core_halt_o, core_rst_req_o});
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      nvec++;
      if ({core_halt_o, core_rst_req_o} !== 2'b00) begin
        nmis++; $display("FAIL rstload_after[%0d]: got halt/rst %b want 00", i, {core_halt_o, core_rst_req_o});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hFFFF_FFFF;
    ram[16] = 32'hDEADBEEF;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hFFFF_FFFF;
    rst_n = 1'b0; ld_mode_i = 1'b0;
    idle_inputs();
    if_addr_i = '0; lsu_addr_i = '0; ld_addr_i = '0;
    lsu_wdata_i = '0; ld_wdata_i = '0; lsu_wem_i = '0; ld_wem_i = '0;
    test_reset();
    test_if_read();
    test_starve();
    test_wem();
    test_random();
    test_drain_load();
    test_reset_in_load();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
